// File: rtl/fft_bin_streamer.sv
// Decimating frame capture into two ping-pong banks, replayed to the formant tracker
// as I back-to-back bins. Optional macro FFT_STREAMER_SATURATE_EN saturates the bin sum.
module fft_bin_streamer #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned I         = 160,
  parameter int unsigned DECIM     = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 fft_valid,
  output logic [BIT_WIDTH-1:0] fft_data,
  input  logic                 formant_valid,
  output logic                 busy,
  output logic [15:0]          dropped_frames
);

  localparam int unsigned KW = $clog2(I + 3);
  localparam int unsigned AW = (I > 1) ? $clog2(I) : 1;
  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {B_EMPTY, B_FULL, B_READING} bank_flag_t;
  typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_STREAM, S_WAIT_DONE} state_t;

  state_t               state;
  bank_flag_t           flag_q [2];
  logic                 newest, wbank, rbank;
  logic [KW-1:0]        k;
  logic [PW-1:0]        phase;
  logic [BIT_WIDTH-1:0] acc;
  logic [KW-1:0]        rd_addr, cnt;
  logic                 rd_en, v1;
  logic [BIT_WIDTH-1:0] q1;
  logic [BIT_WIDTH-1:0] mem [2][I];

  logic                 claim_c, release_c, sel_c;
  bank_flag_t           flag_s [2];
  logic                 first_c, wr_bank_c, accept_c, grp_end_c, full_frame_c;
  logic                 drop_first_c, drop_short_c;
  logic [BIT_WIDTH-1:0] sum_c;
  logic [16:0]          drop_sum_c;
`ifdef FFT_STREAMER_SATURATE_EN
  logic [BIT_WIDTH:0]   add_c;
`endif

  // Stream-side flag changes are resolved first so capture decisions see them.
  always_comb begin
    claim_c   = (state == S_IDLE) && ((flag_q[0] == B_FULL) || (flag_q[1] == B_FULL));
    sel_c     = (flag_q[newest] == B_FULL) ? newest : ~newest;
    release_c = (state == S_STREAM) && (cnt == KW'(I - 1));
    flag_s[0] = flag_q[0];
    flag_s[1] = flag_q[1];
    if (claim_c)   flag_s[sel_c] = B_READING;
    if (release_c) flag_s[rbank] = B_EMPTY;

    first_c   = in_valid && (k == '0) && (phase == '0);
    wr_bank_c = wbank;
    if (first_c && (flag_s[wbank] == B_READING)) wr_bank_c = ~wbank;

    accept_c     = in_valid && (k < KW'(I));
    grp_end_c    = accept_c && (phase == PW'(DECIM - 1));
    full_frame_c = (k == KW'(I)) || (grp_end_c && (k == KW'(I - 1)));
    drop_first_c = first_c && (flag_s[wr_bank_c] == B_FULL);
    drop_short_c = in_valid && in_last && !full_frame_c;
    drop_sum_c   = {1'b0, dropped_frames} + 17'(drop_first_c) + 17'(drop_short_c);

`ifdef FFT_STREAMER_SATURATE_EN
    add_c = {1'b0, acc} + {1'b0, in_data};
    sum_c = add_c[BIT_WIDTH] ? '1 : add_c[BIT_WIDTH-1:0];
`else
    sum_c = acc + in_data;
`endif
    if (phase == '0) sum_c = in_data;
  end

  // Bank storage with a two-stage registered read path.
  always_ff @(posedge clk_in) begin
    if (grp_end_c) mem[wr_bank_c][AW'(k)] <= sum_c;
    if (rd_en)     q1 <= mem[rbank][AW'(rd_addr)];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      flag_q[0]      <= B_EMPTY;
      flag_q[1]      <= B_EMPTY;
      newest         <= 1'b0;
      wbank          <= 1'b0;
      rbank          <= 1'b0;
      k              <= '0;
      phase          <= '0;
      acc            <= '0;
      rd_addr        <= '0;
      cnt            <= '0;
      rd_en          <= 1'b0;
      v1             <= 1'b0;
      fft_valid      <= 1'b0;
      fft_data       <= '0;
      busy           <= 1'b0;
      dropped_frames <= '0;
    end else begin
      // Capture: sample position, accumulation and frame bookkeeping
      if (in_valid) begin
        if (in_last) begin
          k     <= '0;
          phase <= '0;
        end else if (k < KW'(I)) begin
          if (phase == PW'(DECIM - 1)) begin
            phase <= '0;
            k     <= k + KW'(1);
          end else begin
            phase <= phase + PW'(1);
          end
        end
      end
      if (accept_c) acc <= sum_c;

      flag_q[0] <= flag_s[0];
      flag_q[1] <= flag_s[1];
      if (drop_first_c) flag_q[wr_bank_c] <= B_EMPTY;
      if (in_valid && in_last && full_frame_c) begin
        flag_q[wr_bank_c] <= B_FULL;
        newest            <= wr_bank_c;
        wbank             <= (flag_s[~wr_bank_c] == B_READING) ? wr_bank_c : ~wr_bank_c;
      end else if (first_c) begin
        wbank <= wr_bank_c;
      end
      dropped_frames <= drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];

      // Output pipeline tracks the read pipeline one-for-one
      v1        <= rd_en;
      fft_valid <= v1;
      if (v1) fft_data <= q1;

      rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (claim_c) begin
            state   <= S_PREFETCH;
            rbank   <= sel_c;
            rd_addr <= '0;
            rd_en   <= 1'b1;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        S_PREFETCH: begin
          rd_addr <= rd_addr + KW'(1);
          rd_en   <= (rd_addr + KW'(1)) < KW'(I);
          if (cnt == KW'(1)) begin
            state <= S_STREAM;
            cnt   <= '0;
          end else begin
            cnt <= cnt + KW'(1);
          end
        end
        S_STREAM: begin
          if (release_c) begin
            state <= S_WAIT_DONE;
          end else begin
            rd_addr <= rd_addr + KW'(1);
            rd_en   <= (rd_addr + KW'(1)) < KW'(I);
            cnt     <= cnt + KW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (formant_valid) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_bin_streamer.md
# fft_bin_streamer

Frame buffer and re-streamer that sits between the FFT power stage and the formant tracker. It accumulates an incoming per-bin power stream into I decimated bins, double-buffers completed frames, and replays one frame as exactly I back-to-back `fft_valid` cycles. It only replays when the tracker is idle, using the tracker's `formant_valid` pulse as the completion handshake.

## Interface
- `BIT_WIDTH`, 32: width of input samples, accumulators and output bins
- `I`, 160: output bins per frame, matching the tracker's I
- `DECIM`, 2: consecutive input bins summed into one output bin; ≥1
- `clk_in` input 1: single clock
- `rst_in` input 1: reset, synchronous, active-high
- `in_valid` input 1: input sample strobe; no backpressure
- `in_data` input BIT_WIDTH: unsigned bin power
- `in_last` input 1: qualified by `in_valid`; marks the last sample of an FFT frame
- `fft_valid` output 1: output bin strobe; high for exactly I consecutive cycles per frame
- `fft_data` output BIT_WIDTH: output bin k, in order k = 0..I-1
- `formant_valid` input 1: one-cycle completion pulse from the tracker
- `busy` output 1: stream FSM not in IDLE
- `dropped_frames` output 16: saturating count of discarded frames

## Operation
- Capture side:
  - Sample counter n resets to 0 after every `in_last`.
  - Output bin k = sum of samples n = k·DECIM … k·DECIM+DECIM-1. The accumulator is written to bank address k on the group's final sample.
  - Samples with n ≥ I·DECIM are ignored.
- Banks: two banks of I words, BRAM with 2-cycle read latency. Each bank holds a flag: EMPTY, FULL or READING.
- Capture never writes a READING bank.
- On the first sample of a frame, if the target bank is FULL: clear the flag and increment `dropped_frames` (stale frame overwritten).
- On `in_last` with n+1 ≥ I·DECIM:
  - Mark the bank FULL and record it as newest.
  - Switch the write bank to the other bank unless that bank is READING.
- On `in_last` with n+1 < I·DECIM (short frame): the bank stays EMPTY, `dropped_frames` increments, and the write bank is unchanged.
- Stream FSM:
  - IDLE → PREFETCH when any bank is FULL. Select the newest FULL bank and mark it READING.
  - PREFETCH lasts 2 cycles, issuing reads for addresses 0 and 1.
  - STREAM lasts I cycles with the address advancing each cycle.
  - After the last bin, the bank → EMPTY and the FSM enters WAIT_DONE.
  - WAIT_DONE → IDLE on a `formant_valid` pulse.
- A `formant_valid` pulse outside WAIT_DONE is ignored.
- A capture `in_last` and a stream bank release in the same cycle are both applied; the release takes effect before the write-bank switch decision.

## Timing
- Reset values: `fft_valid`=0, `fft_data`=0, `busy`=0, `dropped_frames`=0, both banks EMPTY, write bank 0, n=0, FSM IDLE.
- Reset mid-frame or mid-stream aborts immediately: `fft_valid` goes low the next cycle and all buffered data is discarded.
- Latency, measured from the cycle `in_last` is sampled with the FSM in IDLE:
  - FSM leaves IDLE at +1.
  - `fft_valid` first high at +3 with bin 0.
  - Last bin at +3+I-1.
  - `fft_valid` is registered and never gaps within a frame.
- `fft_data` holds its last value while `fft_valid` is low.
- `busy` is high from PREFETCH through WAIT_DONE inclusive.
- Capture accepts `in_valid` every cycle, including while streaming.

## Configuration
- `FFT_STREAMER_SATURATE_EN` defined: the accumulator add saturates at 2^BIT_WIDTH-1.
- Not defined: the add wraps modulo 2^BIT_WIDTH.

## Test plan
- **Single frame:** 512 samples with `in_data`=n and `in_last` on n=511; the FSM is IDLE.
  - `fft_valid` high for exactly 160 consecutive cycles starting 3 cycles after `in_last`.
  - `fft_data`[k] = 4k+1.
  - `dropped_frames`=0.
- **Handshake:** after the streamed frame, hold `formant_valid` low and send a second frame.
  - No `fft_valid` until `formant_valid` pulses.
  - The second frame then streams 3 cycles after the pulse.
- **Overrun:** three full frames back-to-back while the FSM sits in WAIT_DONE.
  - `dropped_frames`=1.
  - The next stream carries frame 3's data.
- **Short frame:** `in_last` at n=299.
  - No stream occurs.
  - `dropped_frames`=1.
  - The next full frame streams normally.
- **Saturation:** samples 0xFFFFFFF0 and 0x20 in one bin.
  - With the macro: bin = 0xFFFFFFFF.
  - Without: bin = 0x00000010.
- **Reset mid-stream:** assert `rst_in` during bin 50.
  - `fft_valid`=0 the next cycle.
  - `busy`=0 and `dropped_frames`=0.
  - No stream occurs until a new full frame arrives.
